// File: rtl/alu_serial_nbit_if.sv
// Operand/control/result bundle between the multi-cycle datapath and the serial ALU.
// The master drives a request and the slave returns a registered result with flags.
interface alu_serial_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             Ainvert;
    logic             Binvert;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zflag;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, Ainvert, Binvert, op,
        input  busy, done, result, zflag, cout, overflow
    );

    modport slave (
        input  start, a, b, Ainvert, Binvert, op,
        output busy, done, result, zflag, cout, overflow
    );
endinterface

// File: rtl/alu_serial_nbit.sv
// Serial N-bit ALU: SLICE bits per cycle, LSB first, ripple carry held in a register.
// AND/OR/ADD/SUB/SLT/NOR with start/busy/done handshake and registered flags.
module alu_serial_nbit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_serial_nbit_if.slave  bus
);
    localparam int NSTEP = WIDTH / SLICE;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    logic [1:0]       r_state;
    logic [SW-1:0]    r_step;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_zflag;
    logic             r_cout;
    logic             r_ovf;
    logic             r_done;

    int               w_sh;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic [SLICE-1:0] w_sum;
    logic [SLICE-1:0] w_slice;
    logic [SLICE:0]   w_c;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_final;
    logic             w_cout;
    logic             w_ovf;
    logic             w_last;

    // Slice datapath for the current step; operands were pre-inverted at accept time.
    always_comb begin
        w_sh    = int'(r_step) * SLICE;
        w_sa    = SLICE'(r_a >> w_sh);
        w_sb    = SLICE'(r_b >> w_sh);
        w_c     = '0;
        w_c[0]  = r_carry;
        w_sum   = '0;
        for (int k = 0; k < SLICE; k++) begin
            w_sum[k]   = w_sa[k] ^ w_sb[k] ^ w_c[k];
            w_c[k+1]   = (w_sa[k] & w_sb[k]) | (w_c[k] & (w_sa[k] ^ w_sb[k]));
        end
        case (r_op)
            2'b00:   w_slice = w_sa & w_sb;
            2'b01:   w_slice = w_sa | w_sb;
            default: w_slice = w_sum;
        endcase
        w_res_next = (r_result & ~(SLICE_MASK << w_sh)) | (WIDTH'(w_slice) << w_sh);
        w_cout     = r_op[1] & w_c[SLICE];
        w_ovf      = r_op[1] & (w_c[SLICE-1] ^ w_c[SLICE]);
        // SLT: sign of (a - b) corrected by overflow gives the signed less-than.
        w_final    = (r_op == 2'b11) ? {{(WIDTH-1){1'b0}}, w_sum[SLICE-1] ^ w_ovf} : w_res_next;
        w_last     = (r_step == SW'(NSTEP - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= 2'b00;
            r_result <= '0;
            r_zflag  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.Ainvert ? ~bus.a : bus.a;
                        r_b     <= ((bus.op == 2'b11) || bus.Binvert) ? ~bus.b : bus.b;
                        r_op    <= bus.op;
                        r_step  <= '0;
                        r_carry <= (bus.op == 2'b11) | ((bus.op == 2'b10) & bus.Binvert);
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry <= w_c[SLICE];
                    if (w_last) begin
                        r_result <= w_final;
                        r_zflag  <= (w_final == '0);
                        r_cout   <= w_cout;
                        r_ovf    <= w_ovf;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end else begin
                        r_result <= w_res_next;
                        r_step   <= r_step + 1'b1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.zflag    = r_zflag;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_alu_serial_nbit.sv
// Bench for alu_serial_nbit: SLICE=1 and SLICE=4 instances, table vectors plus handshake sequences.
module tb_alu_serial_nbit;
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ai;
        logic       bi;
        logic [1:0] op;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       v;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    vec_t vt[16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_nbit_if #(.WIDTH(8)) bus1 ();
    alu_serial_nbit_if #(.WIDTH(8)) bus2 ();

    alu_serial_nbit #(.WIDTH(8), .SLICE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    alu_serial_nbit #(.WIDTH(8), .SLICE(4)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Whole-word reference: plain integer add, overflow from operand/result signs.
    function automatic vec_t model(input vec_t v);
        vec_t       r;
        logic [7:0] ea, eb, s;
        logic [8:0] sum;
        logic       cin, ov;
        r   = v;
        ea  = v.ai ? ~v.a : v.a;
        eb  = (v.op == 2'b11 || v.bi) ? ~v.b : v.b;
        cin = (v.op == 2'b11) ? 1'b1 : (v.op == 2'b10) ? v.bi : 1'b0;
        sum = {1'b0, ea} + {1'b0, eb} + {8'd0, cin};
        s   = sum[7:0];
        ov  = (ea[7] == eb[7]) && (s[7] != ea[7]);
        case (v.op)
            2'b00:   begin r.res = ea & eb; r.c = 1'b0;   r.v = 1'b0; end
            2'b01:   begin r.res = ea | eb; r.c = 1'b0;   r.v = 1'b0; end
            2'b10:   begin r.res = s;       r.c = sum[8]; r.v = ov;   end
            default: begin r.res = {7'd0, s[7] ^ ov}; r.c = sum[8]; r.v = ov; end
        endcase
        r.z = (r.res == 8'h00);
        return r;
    endfunction

    task automatic score(input string tag, input exp_t e, input logic [7:0] res,
                         input logic z, input logic c, input logic v, input int lat);
        chk({tag, "_result"},   res, e.res);
        chk({tag, "_zflag"},    z,   e.z);
        chk({tag, "_cout"},     c,   e.c);
        chk({tag, "_overflow"}, v,   e.v);
        chk({tag, "_done_cycle"}, cyc - e.acc + 1, lat);
    endtask

    always @(negedge clk) begin
        if (bus1.done === 1'b1) begin
            if (q1.size() == 0) chk("dut1_unexpected_done", 1, 0);
            else begin
                e1 = q1.pop_front();
                score("dut1", e1, bus1.result, bus1.zflag, bus1.cout, bus1.overflow, 9);
            end
        end
    end

    always @(negedge clk) begin
        if (bus2.done === 1'b1) begin
            if (q2.size() == 0) chk("dut2_unexpected_done", 1, 0);
            else begin
                e2 = q2.pop_front();
                score("dut2", e2, bus2.result, bus2.zflag, bus2.cout, bus2.overflow, 3);
            end
        end
    end

    function automatic exp_t to_exp(input vec_t v, input int acc);
        exp_t e;
        e.res = v.res; e.z = v.z; e.c = v.c; e.v = v.v; e.acc = acc;
        return e;
    endfunction

    task automatic drive(input int sel, input vec_t v, input logic st);
        if (sel == 1) begin
            bus1.a = v.a; bus1.b = v.b; bus1.Ainvert = v.ai; bus1.Binvert = v.bi;
            bus1.op = v.op; bus1.start = st;
        end else begin
            bus2.a = v.a; bus2.b = v.b; bus2.Ainvert = v.ai; bus2.Binvert = v.bi;
            bus2.op = v.op; bus2.start = st;
        end
    endtask

    task automatic wait_idle(input int sel);
        int t = 0;
        @(negedge clk);
        while (((sel == 1) ? bus1.busy : bus2.busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("idle_timeout", 0, 1);
    endtask

    // Accepts one operation, queues its expectation, then scrambles the operand inputs.
    task automatic issue(input int sel, input vec_t v, input logic push);
        vec_t junk;
        wait_idle(sel);
        drive(sel, v, 1'b1);
        @(posedge clk);
        #1;
        if (push) begin
            if (sel == 1) q1.push_back(to_exp(v, cyc));
            else          q2.push_back(to_exp(v, cyc));
        end
        junk.a = 8'($urandom); junk.b = 8'($urandom); junk.ai = 1'($urandom);
        junk.bi = 1'($urandom); junk.op = 2'($urandom);
        drive(sel, junk, 1'b0);
    endtask

    task automatic wait_q(input int sel);
        int t = 0;
        while (((sel == 1) ? q1.size() : q2.size()) != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("done_timeout", 0, 1);
    endtask

    function automatic vec_t mk(input logic [7:0] a, b, input logic ai, bi, input logic [1:0] op,
                                input logic [7:0] res, input logic z, c, v);
        vec_t r;
        r.a = a; r.b = b; r.ai = ai; r.bi = bi; r.op = op;
        r.res = res; r.z = z; r.c = c; r.v = v;
        return r;
    endfunction

    initial begin
        vec_t v, rnd;
        vt[0] = mk(8'h7F, 8'h01, 0, 0, 2'b10, 8'h80, 0, 0, 1);
        vt[1] = mk(8'h05, 8'h05, 0, 1, 2'b10, 8'h00, 1, 1, 0);
        vt[2] = mk(8'hFD, 8'h02, 0, 0, 2'b11, 8'h01, 0, 1, 0);
        vt[3] = mk(8'h80, 8'h7F, 0, 0, 2'b11, 8'h01, 0, 1, 1);
        vt[4] = mk(8'h02, 8'hFD, 0, 0, 2'b11, 8'h00, 1, 0, 0);
        vt[5] = mk(8'hF0, 8'h0F, 1, 1, 2'b00, 8'h00, 1, 0, 0);
        vt[6] = mk(8'hA0, 8'h05, 0, 0, 2'b01, 8'hA5, 0, 0, 0);
        vt[7] = mk(8'hFF, 8'h01, 0, 0, 2'b10, 8'h00, 1, 1, 0);
        vt[8] = mk(8'hCC, 8'hAA, 0, 0, 2'b00, 8'h88, 0, 0, 0);
        vt[9] = mk(8'h03, 8'h05, 0, 1, 2'b10, 8'hFE, 0, 0, 0);
        for (int i = 10; i < 16; i++) begin
            rnd = mk(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                     8'h00, 0, 0, 0);
            vt[i] = model(rnd);
        end

        reset = 1'b1;
        drive(1, vt[0], 1'b0);
        drive(2, vt[0], 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_busy",     bus1.busy,     0);
        chk("rst_done",     bus1.done,     0);
        chk("rst_result",   bus1.result,   0);
        chk("rst_zflag",    bus1.zflag,    0);
        chk("rst_cout",     bus1.cout,     0);
        chk("rst_overflow", bus1.overflow, 0);
        chk("rst_result2",  bus2.result,   0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(1, vt[i], 1'b1);
            wait_q(1);
        end

        // Start pulse during a run must be ignored: one done, original result.
        issue(1, vt[0], 1'b1);
        @(negedge clk);
        @(negedge clk);
        v = mk(8'h11, 8'h22, 0, 0, 2'b01, 8'h00, 0, 0, 0);
        drive(1, v, 1'b1);
        chk("busy_at_restart", bus1.busy, 1);
        @(negedge clk);
        bus1.start = 1'b0;
        wait_q(1);
        repeat (12) @(negedge clk);

        // Reset in the middle of a run: no done, outputs cleared.
        issue(1, vt[0], 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_busy",     bus1.busy,     0);
        chk("midrst_done",     bus1.done,     0);
        chk("midrst_result",   bus1.result,   0);
        chk("midrst_cout",     bus1.cout,     0);
        chk("midrst_overflow", bus1.overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_idle", bus1.busy, 0);

        // SLICE=4 instance: single op, then two back-to-back ops with start held high.
        issue(2, vt[7], 1'b1);
        wait_q(2);
        wait_idle(2);
        v = mk(8'h3C, 8'h44, 0, 0, 2'b10, 8'h80, 0, 0, 1);
        drive(2, v, 1'b1);
        @(posedge clk);
        #1;
        q2.push_back(to_exp(v, cyc));
        repeat (4) @(posedge clk);
        #1;
        q2.push_back(to_exp(v, cyc));
        bus2.start = 1'b0;
        wait_q(2);
        repeat (8) @(negedge clk);

        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
